alu_operand_stage: RTL and testbench

- ID/EX pipeline stage directly upstream of the ALU; produces the registered A, B and AluOp the ALU consumes.
- Selects operands: rs1 or PC for A, rs2 or immediate for B.
- Applies EX/MEM and MEM/WB result forwarding and registers everything behind a valid/ready handshake with stall and flush.
- Also carries rd address and forwarded rs2 (store data) to later stages.

---
 rtl/alu_operand_stage.sv | 96 +++++++++
 tb/tb_alu_operand_stage.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - ID/EX operand stage feeding the ALU; forwarding enabled by ALU_OPERAND_FORWARD_EN
module alu_operand_stage #(
    parameter int XLEN    = 32,
    parameter int ALUOP_W = 4,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    rs1_data,
    input  logic [XLEN-1:0]    rs2_data,
    input  logic [RADDR_W-1:0] rs1_addr,
    input  logic [RADDR_W-1:0] rs2_addr,
    input  logic [XLEN-1:0]    pc,
    input  logic [XLEN-1:0]    imm,
    input  logic               alua_src,
    input  logic               alub_src,
    input  logic [ALUOP_W-1:0] alu_op_in,
    input  logic [RADDR_W-1:0] rd_in,
    input  logic               flush,
    input  logic               exm_wen,
    input  logic [RADDR_W-1:0] exm_rd,
    input  logic [XLEN-1:0]    exm_data,
    input  logic               wb_wen,
    input  logic [RADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]    wb_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    A,
    output logic [XLEN-1:0]    B,
    output logic [ALUOP_W-1:0] AluOp,
    output logic [RADDR_W-1:0] rd_out,
    output logic [XLEN-1:0]    store_data
);

    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;
    logic            accept;

    // A flush blocks acceptance so the killed slot cannot be refilled in the same cycle
    assign in_ready = (!out_valid || out_ready) && !flush;
    assign accept   = in_valid && in_ready;

`ifdef ALU_OPERAND_FORWARD_EN
    // Resolve hazards: the younger EX/MEM result beats MEM/WB; x0 always reads the register file
    always_comb begin
        fwd_rs1 = rs1_data;
        fwd_rs2 = rs2_data;
        if (exm_wen && (exm_rd != '0) && (exm_rd == rs1_addr)) begin
            fwd_rs1 = exm_data;
        end else if (wb_wen && (wb_rd != '0) && (wb_rd == rs1_addr)) begin
            fwd_rs1 = wb_data;
        end
        if (exm_wen && (exm_rd != '0) && (exm_rd == rs2_addr)) begin
            fwd_rs2 = exm_data;
        end else if (wb_wen && (wb_rd != '0) && (wb_rd == rs2_addr)) begin
            fwd_rs2 = wb_data;
        end
    end
`else
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{exm_wen, exm_rd, exm_data, wb_wen, wb_rd, wb_data,
                                 rs1_addr, rs2_addr};

    // Without forwarding the register file values are used as-is
    always_comb begin
        fwd_rs1 = rs1_data;
        fwd_rs2 = rs2_data;
    end
`endif

    // Pipeline register: reset clears, flush kills, accept loads, a drained slot keeps stale data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            A          <= '0;
            B          <= '0;
            AluOp      <= '0;
            rd_out     <= '0;
            store_data <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            A          <= alua_src ? pc  : fwd_rs1;
            B          <= alub_src ? imm : fwd_rs2;
            AluOp      <= alu_op_in;
            rd_out     <= rd_in;
            store_data <= fwd_rs2;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb/tb_alu_operand_stage.sv - directed table-driven bench for alu_operand_stage
module tb_alu_operand_stage;

`ifdef ALU_OPERAND_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] rs1_data, rs2_data;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] pc, imm;
    logic        alua_src, alub_src;
    logic [3:0]  alu_op_in;
    logic [4:0]  rd_in;
    logic        flush;
    logic        exm_wen;
    logic [4:0]  exm_rd;
    logic [31:0] exm_data;
    logic        wb_wen;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] A, B;
    logic [3:0]  AluOp;
    logic [4:0]  rd_out;
    logic [31:0] store_data;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        asrc;
        logic        bsrc;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        exm_wen;
        logic [4:0]  exm_rd;
        logic [31:0] exm_data;
        logic        wb_wen;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic [31:0] exp_sd;
    } vec_t;

    vec_t vecs[7];

    alu_operand_stage #(.XLEN(32), .ALUOP_W(4), .RADDR_W(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .pc(pc), .imm(imm), .alua_src(alua_src), .alub_src(alub_src),
        .alu_op_in(alu_op_in), .rd_in(rd_in), .flush(flush),
        .exm_wen(exm_wen), .exm_rd(exm_rd), .exm_data(exm_data),
        .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .A(A), .B(B), .AluOp(AluOp), .rd_out(rd_out), .store_data(store_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        rs1_data  = v.rs1_data;  rs2_data = v.rs2_data;
        rs1_addr  = v.rs1_addr;  rs2_addr = v.rs2_addr;
        pc        = v.pc;        imm      = v.imm;
        alua_src  = v.asrc;      alub_src = v.bsrc;
        alu_op_in = v.op;        rd_in    = v.rd;
        exm_wen   = v.exm_wen;   exm_rd   = v.exm_rd;  exm_data = v.exm_data;
        wb_wen    = v.wb_wen;    wb_rd    = v.wb_rd;   wb_data  = v.wb_data;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t s;
        // basic issue
        vecs[0] = '{rs1_data:32'd5, rs2_data:32'd3, rs1_addr:5'd1, rs2_addr:5'd2, pc:32'h0, imm:32'h0,
                    asrc:1'b0, bsrc:1'b0, op:4'b1000, rd:5'd3, exm_wen:1'b0, exm_rd:5'd0, exm_data:32'h0,
                    wb_wen:1'b0, wb_rd:5'd0, wb_data:32'h0, exp_a:32'd5, exp_b:32'd3, exp_sd:32'd3};
        // PC / immediate selection, store_data still carries rs2
        vecs[1] = '{rs1_data:32'h9, rs2_data:32'd7, rs1_addr:5'd1, rs2_addr:5'd2, pc:32'h100, imm:32'hFFFFFFFC,
                    asrc:1'b1, bsrc:1'b1, op:4'b0001, rd:5'd4, exm_wen:1'b0, exm_rd:5'd0, exm_data:32'h0,
                    wb_wen:1'b0, wb_rd:5'd0, wb_data:32'h0, exp_a:32'h100, exp_b:32'hFFFFFFFC, exp_sd:32'd7};
        // both sources match rs1: EX/MEM wins
        vecs[2] = '{rs1_data:32'h11, rs2_data:32'h22, rs1_addr:5'd4, rs2_addr:5'd5, pc:32'h0, imm:32'h0,
                    asrc:1'b0, bsrc:1'b0, op:4'b0010, rd:5'd6, exm_wen:1'b1, exm_rd:5'd4, exm_data:32'hAA,
                    wb_wen:1'b1, wb_rd:5'd4, wb_data:32'hBB, exp_a:(FWD ? 32'hAA : 32'h11),
                    exp_b:32'h22, exp_sd:32'h22};
        // EX/MEM not writing: MEM/WB supplies rs1
        vecs[3] = '{rs1_data:32'h11, rs2_data:32'h22, rs1_addr:5'd4, rs2_addr:5'd5, pc:32'h0, imm:32'h0,
                    asrc:1'b0, bsrc:1'b0, op:4'b0011, rd:5'd7, exm_wen:1'b0, exm_rd:5'd4, exm_data:32'hAA,
                    wb_wen:1'b1, wb_rd:5'd4, wb_data:32'hBB, exp_a:(FWD ? 32'hBB : 32'h11),
                    exp_b:32'h22, exp_sd:32'h22};
        // x0 is never forwarded
        vecs[4] = '{rs1_data:32'h33, rs2_data:32'h0, rs1_addr:5'd0, rs2_addr:5'd0, pc:32'h0, imm:32'h0,
                    asrc:1'b0, bsrc:1'b0, op:4'b0100, rd:5'd8, exm_wen:1'b1, exm_rd:5'd0, exm_data:32'hAA,
                    wb_wen:1'b1, wb_rd:5'd0, wb_data:32'hBB, exp_a:32'h33, exp_b:32'h0, exp_sd:32'h0};
        // rs2 forwarded from MEM/WB into store_data while B takes the immediate
        vecs[5] = '{rs1_data:32'h1, rs2_data:32'h55, rs1_addr:5'd9, rs2_addr:5'd7, pc:32'h0, imm:32'h44,
                    asrc:1'b0, bsrc:1'b1, op:4'b0101, rd:5'd10, exm_wen:1'b1, exm_rd:5'd6, exm_data:32'hAA,
                    wb_wen:1'b1, wb_rd:5'd7, wb_data:32'hCC, exp_a:32'h1, exp_b:32'h44,
                    exp_sd:(FWD ? 32'hCC : 32'h55)};
        // undefined AluOp passes through verbatim
        vecs[6] = '{rs1_data:32'hDEADBEEF, rs2_data:32'h12345678, rs1_addr:5'd11, rs2_addr:5'd12, pc:32'h0,
                    imm:32'h0, asrc:1'b0, bsrc:1'b0, op:4'b1111, rd:5'd31, exm_wen:1'b0, exm_rd:5'd0,
                    exm_data:32'h0, wb_wen:1'b0, wb_rd:5'd0, wb_data:32'h0, exp_a:32'hDEADBEEF,
                    exp_b:32'h12345678, exp_sd:32'h12345678};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        apply(vecs[0]);
        tick(); tick();
        rst = 1'b0;
        #1;
        check("reset out_valid", {31'b0, out_valid}, 32'd0);
        check("reset A", A, 32'd0);
        check("reset in_ready", {31'b0, in_ready}, 32'd1);

        // back-to-back issue, one instruction per cycle
        for (int i = 0; i < 7; i++) begin
            apply(vecs[i]);
            in_valid = 1'b1;
            tick();
            check($sformatf("v%0d out_valid", i), {31'b0, out_valid}, 32'd1);
            check($sformatf("v%0d A", i), A, vecs[i].exp_a);
            check($sformatf("v%0d B", i), B, vecs[i].exp_b);
            check($sformatf("v%0d store_data", i), store_data, vecs[i].exp_sd);
            check($sformatf("v%0d AluOp", i), {28'b0, AluOp}, {28'b0, vecs[i].op});
            check($sformatf("v%0d rd_out", i), {27'b0, rd_out}, {27'b0, vecs[i].rd});
        end

        // drain: no new instruction, outputs keep last values
        in_valid = 1'b0;
        tick();
        check("drain out_valid", {31'b0, out_valid}, 32'd0);
        check("drain A hold", A, 32'hDEADBEEF);

        // stall: load vecs[0], then hold it 3 cycles while inputs change
        apply(vecs[0]); in_valid = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            s = vecs[1 + c];
            apply(s);
            #1;
            check($sformatf("stall%0d in_ready", c), {31'b0, in_ready}, 32'd0);
            tick();
            check($sformatf("stall%0d out_valid", c), {31'b0, out_valid}, 32'd1);
            check($sformatf("stall%0d A", c), A, 32'd5);
            check($sformatf("stall%0d B", c), B, 32'd3);
            check($sformatf("stall%0d AluOp", c), {28'b0, AluOp}, 32'h8);
        end
        // release: vecs[1] accepted this cycle, visible one cycle later
        apply(vecs[1]); out_ready = 1'b1;
        #1;
        check("release in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        check("release A", A, 32'h100);
        check("release B", B, 32'hFFFFFFFC);

        // flush while stalled with a pending input
        out_ready = 1'b0; apply(vecs[6]); in_valid = 1'b1; flush = 1'b1;
        #1;
        check("flush in_ready", {31'b0, in_ready}, 32'd0);
        tick();
        check("flush out_valid", {31'b0, out_valid}, 32'd0);
        check("flush no load", A, 32'h100);
        flush = 1'b0;
        #1;
        check("post-flush in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        check("post-flush out_valid", {31'b0, out_valid}, 32'd1);
        check("post-flush A", A, 32'hDEADBEEF);
        check("post-flush AluOp", {28'b0, AluOp}, 32'hF);

        // asynchronous reset mid-stall, together with flush, checked before any edge
        apply(vecs[0]); tick();
        flush = 1'b1; rst = 1'b1;
        #1;
        check("async rst out_valid", {31'b0, out_valid}, 32'd0);
        check("async rst A", A, 32'd0);
        check("async rst B", B, 32'd0);
        check("async rst store_data", store_data, 32'd0);
        check("async rst AluOp", {28'b0, AluOp}, 32'd0);
        check("async rst rd_out", {27'b0, rd_out}, 32'd0);
        tick();
        rst = 1'b0; flush = 1'b0; out_ready = 1'b1;
        tick();
        check("after rst accept", A, 32'd5);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
